// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding RV32 load/store with a fixed number of wait states,
// byte/halfword/word lanes with sign or zero extension, and an error response for bad requests.
module dmem_responder #(
    parameter int unsigned DWIDTH      = 32,
    parameter int unsigned AWIDTH      = 32,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDXW = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [2:0]        r_size;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata;
    logic [DWIDTH-1:0] r_rdata;
    logic              r_err;
    logic [DWIDTH-1:0] r_mem [DEPTH_WORDS];

    logic [IDXW-1:0]   w_idx;
    logic [AWIDTH-1:0] w_word_addr;
    logic [4:0]        w_lane_shift;
    logic [DWIDTH-1:0] w_word;
    logic [DWIDTH-1:0] w_rd_shift;
    logic [DWIDTH-1:0] w_wdata_sh;
    logic [DWIDTH-1:0] w_load;
    logic [3:0]        w_be;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_oor;
    logic              w_err;
    logic              w_access;
    logic              w_mem_we;

    assign w_idx        = r_addr[IDXW+1:2];
    assign w_word_addr  = {2'b00, r_addr[AWIDTH-1:2]};
    assign w_lane_shift = {r_addr[1:0], 3'b000};
    assign w_word       = r_mem[w_idx];
    assign w_rd_shift   = w_word >> w_lane_shift;
    assign w_wdata_sh   = r_wdata << w_lane_shift;

    assign w_illegal  = (r_size == 3'b011) || (r_size == 3'b110) || (r_size == 3'b111)
                        || (r_we && r_size[2]);
    assign w_misalign = ((r_size[1:0] == 2'b01) && r_addr[0])
                        || ((r_size[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
    assign w_oor      = (w_word_addr >= AWIDTH'(DEPTH_WORDS));
    assign w_err      = w_illegal || w_misalign || w_oor;

    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_mem_we = w_access && r_we && !w_err;

    always_comb begin
        w_load = '0;
        case (r_size)
            3'b000:  w_load = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            3'b001:  w_load = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            3'b010:  w_load = w_rd_shift;
            3'b100:  w_load = {24'd0, w_rd_shift[7:0]};
            3'b101:  w_load = {16'd0, w_rd_shift[15:0]};
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_be = 4'b1111;
        case (r_size[1:0])
            2'b00:   w_be = 4'b0001 << r_addr[1:0];
            2'b01:   w_be = 4'b0011 << r_addr[1:0];
            default: w_be = 4'b1111;
        endcase
    end

    // Backing array is intentionally not reset; a store only lands on its access edge.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_cnt   <= LAT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_rdata <= (w_err || r_we) ? '0 : w_load;
                        r_err   <= w_err;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 4, 0) share request fields
// and each has its own req_valid; every scenario task checks its own expected values.
`timescale 1ns/1ps
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  vld = 3'b000;
    logic        we = 1'b0;
    logic [2:0]  size = 3'b010;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        rsp_ready = 1'b1;

    logic [2:0]  req_ready_v;
    logic [2:0]  rsp_valid_v;
    logic [2:0]  rsp_err_v;
    logic [31:0] rsp_rdata_v [3];

    int errors = 0;
    int checks = 0;

    logic [31:0] rd;
    logic        e;
    logic        ra;
    int          lat;

    always #5 clk = ~clk;

    dmem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(req_ready_v[0]), .req_we(we),
        .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsp_valid_v[0]),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[0]), .rsp_err(rsp_err_v[0])
    );

    dmem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH_WORDS(64), .LATENCY(4)) u_dut_l4 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(req_ready_v[1]), .req_we(we),
        .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsp_valid_v[1]),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[1]), .rsp_err(rsp_err_v[1])
    );

    dmem_responder #(.DWIDTH(32), .AWIDTH(32), .DEPTH_WORDS(64), .LATENCY(0)) u_dut_l0 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(req_ready_v[2]), .req_we(we),
        .req_size(size), .req_addr(addr), .req_wdata(wdata), .rsp_valid(rsp_valid_v[2]),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_v[2]), .rsp_err(rsp_err_v[2])
    );

    // One full transaction; lat = edges from accept to rsp_valid, rdy_after = req_ready
    // in the cycle after the response handshake. Request fields are scrambled during WAIT.
    task automatic do_req(input int sel, input logic w, input logic [2:0] sz,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdo, output logic eo, output int lato,
                          output logic rdy_after);
        int n;
        @(negedge clk);
        we = w; size = sz; addr = a; wdata = d; vld[sel] = 1'b1;
        n = 0;
        while (!req_ready_v[sel] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout inst=%0d waited=%0d cycles want <20", sel, n);
        end
        @(posedge clk);
        @(negedge clk);
        vld[sel] = 1'b0; we = ~w; size = 3'b010; addr = 32'h3C; wdata = 32'hFFFF_FFFF;
        lato = 0;
        while (!rsp_valid_v[sel] && lato < 40) begin
            @(posedge clk);
            lato++;
            @(negedge clk);
        end
        if (lato >= 40) begin
            checks++; errors++;
            $display("FAIL rsp_valid_timeout inst=%0d waited=%0d cycles want <40", sel, lato);
        end
        rdo = rsp_rdata_v[sel];
        eo  = rsp_err_v[sel];
        @(posedge clk);
        @(negedge clk);
        rdy_after = req_ready_v[sel];
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if (req_ready_v[0] !== 1'b1) begin
            errors++; $display("FAIL reset_req_ready got=%b want=1", req_ready_v[0]);
        end
        checks++;
        if (rsp_valid_v[0] !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid_v[0]);
        end
        checks++;
        if (rsp_rdata_v[0] !== 32'h0) begin
            errors++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata_v[0]);
        end
        checks++;
        if (rsp_err_v[0] !== 1'b0) begin
            errors++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err_v[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_word();
        do_req(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, e, lat, ra);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0 || lat != 3 || ra !== 1'b1) begin
            errors++;
            $display("FAIL sw_word got err=%b rdata=%h lat=%0d rdy=%b want 0 0 3 1", e, rd, lat, ra);
        end
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat, ra);
        checks++;
        if (e !== 1'b0 || rd !== 32'hDEAD_BEEF || lat != 3) begin
            errors++;
            $display("FAIL lw_word got err=%b rdata=%h lat=%0d want 0 deadbeef 3", e, rd, lat);
        end
    endtask

    task automatic test_subword();
        do_req(0, 1'b1, 3'b010, 32'h10, 32'h1122_3344, rd, e, lat, ra);
        do_req(0, 1'b1, 3'b000, 32'h13, 32'h1234_5680, rd, e, lat, ra);
        checks++;
        if (e !== 1'b0 || rd !== 32'h0) begin
            errors++; $display("FAIL sb_rsp got err=%b rdata=%h want 0 0", e, rd);
        end
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h8022_3344) begin
            errors++; $display("FAIL sb_merge got=%h want=80223344", rd);
        end
        do_req(0, 1'b0, 3'b000, 32'h13, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'hFFFF_FF80 || e !== 1'b0) begin
            errors++; $display("FAIL lb_sext got=%h err=%b want=ffffff80", rd, e);
        end
        do_req(0, 1'b0, 3'b100, 32'h13, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h0000_0080) begin
            errors++; $display("FAIL lbu_zext got=%h want=00000080", rd);
        end
        do_req(0, 1'b0, 3'b101, 32'h12, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h0000_8022) begin
            errors++; $display("FAIL lhu_zext got=%h want=00008022", rd);
        end
        do_req(0, 1'b0, 3'b001, 32'h12, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'hFFFF_8022) begin
            errors++; $display("FAIL lh_sext got=%h want=ffff8022", rd);
        end
        do_req(0, 1'b1, 3'b001, 32'h10, 32'h9999_ABCD, rd, e, lat, ra);
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h8022_ABCD) begin
            errors++; $display("FAIL sh_merge got=%h want=8022abcd", rd);
        end
        do_req(0, 1'b0, 3'b000, 32'h11, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'hFFFF_FFAB) begin
            errors++; $display("FAIL lb_lane1 got=%h want=ffffffab", rd);
        end
        do_req(0, 1'b0, 3'b100, 32'h10, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h0000_00CD) begin
            errors++; $display("FAIL lbu_lane0 got=%h want=000000cd", rd);
        end
    endtask

    task automatic test_errors();
        logic [2:0]  sz_t [8];
        logic        we_t [8];
        logic [31:0] a_t  [8];
        sz_t = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b011, 3'b110, 3'b110};
        we_t = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
        a_t  = '{32'h11, 32'h12, 32'h0E, 32'h1000, 32'h100C, 32'h10, 32'h10, 32'h0C};
        do_req(0, 1'b1, 3'b010, 32'h0C, 32'h0C0C_0C0C, rd, e, lat, ra);
        for (int i = 0; i < 8; i++) begin
            do_req(0, we_t[i], sz_t[i], a_t[i], 32'hFFFF_FFFF, rd, e, lat, ra);
            checks++;
            if (e !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL err_case%0d got err=%b rdata=%h want err=1 rdata=0", i, e, rd);
            end
        end
        do_req(0, 1'b1, 3'b100, 32'h0C, 32'h0, rd, e, lat, ra);
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("FAIL err_store_sz100 got err=%b want=1", e);
        end
        do_req(0, 1'b0, 3'b010, 32'h0C, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h0C0C_0C0C || e !== 1'b0) begin
            errors++; $display("FAIL err_no_write got=%h err=%b want=0c0c0c0c", rd, e);
        end
        do_req(0, 1'b1, 3'b010, 32'hFFC, 32'h1234_5678, rd, e, lat, ra);
        do_req(0, 1'b0, 3'b010, 32'hFFC, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h1234_5678 || e !== 1'b0) begin
            errors++; $display("FAIL last_word got=%h err=%b want=12345678", rd, e);
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        rsp_ready = 1'b0; we = 1'b0; size = 3'b010; addr = 32'h10; vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        n = 0;
        while (!rsp_valid_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL bp_rsp_timeout waited=%0d want <20", n);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid_v[0] !== 1'b1 || rsp_rdata_v[0] !== 32'h8022_ABCD
                || req_ready_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b rdata=%h ready=%b want 1 8022abcd 0",
                         i, rsp_valid_v[0], rsp_rdata_v[0], req_ready_v[0]);
            end
            if (i == 1) begin
                vld[0] = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'h0; size = 3'b010;
            end
            if (i == 2) vld[0] = 1'b0;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready_v[0] !== 1'b1 || rsp_valid_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got ready=%b valid=%b want 1 0",
                     req_ready_v[0], rsp_valid_v[0]);
        end
        do_req(0, 1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h8022_ABCD) begin
            errors++; $display("FAIL bp_pulse_ignored got=%h want=8022abcd", rd);
        end
    endtask

    task automatic test_reset_mid();
        do_req(1, 1'b1, 3'b010, 32'h20, 32'h1111_1111, rd, e, lat, ra);
        do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h1111_1111 || lat != 5) begin
            errors++; $display("FAIL l4_preload got=%h lat=%0d want 11111111 5", rd, lat);
        end
        @(negedge clk);
        vld[1] = 1'b1; we = 1'b1; size = 3'b010; addr = 32'h20; wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        @(negedge clk);
        vld[1] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready_v[1] !== 1'b1 || rsp_valid_v[1] !== 1'b0 || rsp_rdata_v[1] !== 32'h0
            || rsp_err_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs got ready=%b valid=%b rdata=%h err=%b want 1 0 0 0",
                     req_ready_v[1], rsp_valid_v[1], rsp_rdata_v[1], rsp_err_v[1]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        do_req(1, 1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'h1111_1111 || e !== 1'b0) begin
            errors++; $display("FAIL midreset_discard got=%h err=%b want=11111111", rd, e);
        end
    endtask

    task automatic test_back_to_back();
        do_req(2, 1'b1, 3'b010, 32'h4, 32'hCAFE_F00D, rd, e, lat, ra);
        checks++;
        if (lat != 1 || ra !== 1'b1 || e !== 1'b0) begin
            errors++; $display("FAIL l0_sw got lat=%0d rdy=%b err=%b want 1 1 0", lat, ra, e);
        end
        do_req(2, 1'b0, 3'b010, 32'h4, 32'h0, rd, e, lat, ra);
        checks++;
        if (lat != 1 || ra !== 1'b1 || rd !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL l0_lw got lat=%0d rdy=%b rdata=%h want 1 1 cafef00d", lat, ra, rd);
        end
        do_req(2, 1'b1, 3'b000, 32'h5, 32'h0000_00EE, rd, e, lat, ra);
        do_req(2, 1'b0, 3'b010, 32'h4, 32'h0, rd, e, lat, ra);
        checks++;
        if (rd !== 32'hCAFE_EE0D) begin
            errors++; $display("FAIL l0_sb_merge got=%h want=cafeee0d", rd);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
